// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states and the
// buffered {pc, instr} entry, sized for the widest supported configuration.
package ifetch_pkg;

   localparam int IFETCH_MAX_ADDRESS_SIZE = 32;
   localparam int IFETCH_MAX_WORD_SIZE    = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchState_e;

   // Narrower configurations zero-extend into these fields.
   typedef struct packed {
      logic [IFETCH_MAX_ADDRESS_SIZE-1:0] pc;
      logic [IFETCH_MAX_WORD_SIZE-1:0]    instr;
   } fetchEntry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction buffer with occupancy count and flush.
// Push and pop in the same cycle on a full buffer both take effect.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic             i_flush,
   input  logic             i_push,
   input  fetchEntry_t      i_pushData,
   input  logic             i_pop,
   output fetchEntry_t      o_headData,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   fetchEntry_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full   = (r_count == CNT_W'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign w_doPop  = i_pop && !o_empty && !i_flush;
   assign w_doPush = i_push && (!o_full || w_doPop) && !i_flush;

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; an entry is only visible once the count covers it.
   always_ff @(posedge i_clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
   end

   assign o_headData = r_mem[r_rdPtr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory reads into a small buffer
// toward decode, with redirect flush. IFETCH_STALL_CNT_EN adds stall_cnt.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int                      WORD_SIZE    = 32,
   parameter int                      ADDRESS_SIZE = 16,
   parameter int                      FIFO_DEPTH   = 2,
   parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDRESS_SIZE-1:0] imem_address,
   output logic                    imem_enable,
   input  logic [WORD_SIZE-1:0]    imem_data,
   input  logic                    imem_data_ready,
   input  logic                    redirect_valid,
   input  logic [ADDRESS_SIZE-1:0] redirect_pc,
   output logic                    if_valid,
   output logic [WORD_SIZE-1:0]    if_instr,
   output logic [ADDRESS_SIZE-1:0] if_pc,
   input  logic                    id_ready,
   output logic                    misalign_err
`ifdef IFETCH_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cnt
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetchState_e             r_state;
   fetchState_e             w_nextState;
   logic [ADDRESS_SIZE-1:0] r_pc;
   logic [ADDRESS_SIZE-1:0] w_nextPc;
   logic                    r_misalign;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_slotAfterPush;
   logic [CNT_W-1:0]        w_count;
   fetchEntry_t             w_pushEntry;
   fetchEntry_t             w_headEntry;

   // A redirect wins over both push and pop in its cycle.
   assign w_pop  = !w_empty && id_ready && !redirect_valid;
   assign w_push = (r_state == WAIT) && imem_data_ready && !redirect_valid;
   assign w_slotAfterPush =
      (w_count + CNT_W'(1) - CNT_W'(w_pop)) < CNT_W'(FIFO_DEPTH);

   assign w_pushEntry = '{pc:    IFETCH_MAX_ADDRESS_SIZE'(r_pc),
                          instr: IFETCH_MAX_WORD_SIZE'(imem_data)};

   ifetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (clk),
      .i_rstN     (rst),
      .i_flush    (redirect_valid),
      .i_push     (w_push),
      .i_pushData (w_pushEntry),
      .i_pop      (w_pop),
      .o_headData (w_headEntry),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_pc       <= w_nextPc;
         r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextPc    = r_pc;
      imem_enable = (r_state != IDLE);
      if (redirect_valid) begin
         w_nextState = REQ;
         w_nextPc    = {redirect_pc[ADDRESS_SIZE-1:2], 2'b00};
      end else begin
         case (r_state)
            IDLE: if (!w_full) w_nextState = REQ;
            REQ:  w_nextState = WAIT;
            WAIT: begin
               if (w_push) begin
                  w_nextPc    = r_pc + ADDRESS_SIZE'(4);
                  w_nextState = w_slotAfterPush ? REQ : IDLE;
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   assign imem_address = r_pc;
   assign if_valid     = !w_empty;
   assign if_pc        = ADDRESS_SIZE'(w_headEntry.pc);
   assign if_instr     = WORD_SIZE'(w_headEntry.instr);
   assign misalign_err = r_misalign;

`ifdef IFETCH_STALL_CNT_EN
   logic [31:0] r_stallCnt;

   // Cycles spent with a read open but nothing delivered; saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stallCnt <= '0;
      end else if (imem_enable && !w_push && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + 32'd1;
      end
   end

   assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: a default instance and a
// RESET_PC=0xFFF8 instance, each fed by a simple latency-controlled memory.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        idReady;
   logic        redirValid;
   logic [15:0] redirPc;

   logic [15:0] addrA, pcA, addrB, pcB;
   logic [31:0] dataA, instrA, dataB, instrB;
   logic        enA, readyA, validA, misA;
   logic        enB, readyB, validB, misB;
`ifdef IFETCH_STALL_CNT_EN
   logic [31:0] stallA, stallB, stallBase;
`endif

   int cntA = 0;
   int cntB = 0;
   int memLat = 1;
   int totalChecks = 0;
   int badChecks = 0;

   logic [15:0] expAddrA [1:7] = '{16'h0000, 16'h0000, 16'h0004, 16'h0004,
                                   16'h0008, 16'h0008, 16'h000C};
   logic [15:0] expPcA   [1:7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                   16'h0004, 16'h0000, 16'h0008};
   logic [15:0] expAddrB [1:7] = '{16'hFFF8, 16'hFFF8, 16'hFFFC, 16'hFFFC,
                                   16'h0000, 16'h0000, 16'h0004};
   logic [15:0] expPcB   [1:7] = '{16'h0000, 16'h0000, 16'hFFF8, 16'h0000,
                                   16'hFFFC, 16'h0000, 16'h0000};
   logic        expValid [1:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   ifetch_unit dutA (
      .clk             (clk),
      .rst             (rst),
      .imem_address    (addrA),
      .imem_enable     (enA),
      .imem_data       (dataA),
      .imem_data_ready (readyA),
      .redirect_valid  (redirValid),
      .redirect_pc     (redirPc),
      .if_valid        (validA),
      .if_instr        (instrA),
      .if_pc           (pcA),
      .id_ready        (idReady),
      .misalign_err    (misA)
`ifdef IFETCH_STALL_CNT_EN
      , .stall_cnt     (stallA)
`endif
   );

   ifetch_unit #(.RESET_PC(16'hFFF8)) dutB (
      .clk             (clk),
      .rst             (rst),
      .imem_address    (addrB),
      .imem_enable     (enB),
      .imem_data       (dataB),
      .imem_data_ready (readyB),
      .redirect_valid  (1'b0),
      .redirect_pc     (16'h0000),
      .if_valid        (validB),
      .if_instr        (instrB),
      .if_pc           (pcB),
      .id_ready        (1'b1),
      .misalign_err    (misB)
`ifdef IFETCH_STALL_CNT_EN
      , .stall_cnt     (stallB)
`endif
   );

   // Memory returns {0xC0DE, address} memLat cycles after the read opens.
   assign dataA  = {16'hC0DE, addrA};
   assign readyA = enA && (cntA >= memLat);
   assign dataB  = {16'hC0DE, addrB};
   assign readyB = enB && (cntB >= 1);

   always @(posedge clk) begin
      if (!enA || readyA || redirValid) cntA <= 0;
      else                              cntA <= cntA + 1;
      if (!enB || readyB)               cntB <= 0;
      else                              cntB <= cntB + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic rv,
                                input logic [15:0] rpc);
      idReady    = rdy;
      redirValid = rv;
      redirPc    = rpc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      idReady = 1'b1;
      redirValid = 1'b0;
      redirPc = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.en", enA, 0);
      checkOutput("rst.valid", validA, 0);
      checkOutput("rst.mis", misA, 0);
      checkOutput("rst.addr", addrA, 16'h0000);
      checkOutput("rst.addrB", addrB, 16'hFFF8);
`ifdef IFETCH_STALL_CNT_EN
      checkOutput("rst.stall", stallA, 0);
`endif
      rst = 1'b1;
      checkOutput("c0.en", enA, 0);
      applyStimulus(1, 0, 0);

      // Streaming fetch with an always-ready decoder; B wraps past 0xFFFC.
      for (int c = 1; c <= 7; c++) begin
         checkOutput($sformatf("c%0d.en", c), enA, 1);
         checkOutput($sformatf("c%0d.addr", c), addrA, expAddrA[c]);
         checkOutput($sformatf("c%0d.valid", c), validA, expValid[c]);
         checkOutput($sformatf("c%0d.addrB", c), addrB, expAddrB[c]);
         checkOutput($sformatf("c%0d.validB", c), validB, expValid[c]);
         if (expValid[c]) begin
            checkOutput($sformatf("c%0d.pc", c), pcA, expPcA[c]);
            checkOutput($sformatf("c%0d.instr", c), instrA, {16'hC0DE, expPcA[c]});
            checkOutput($sformatf("c%0d.pcB", c), pcB, expPcB[c]);
            checkOutput($sformatf("c%0d.instrB", c), instrB, {16'hC0DE, expPcB[c]});
         end
         applyStimulus((c == 7) ? 1'b0 : 1'b1, 0, 0);
      end

      // Decoder stalls: buffer fills to two entries and fetch goes idle.
      checkOutput("c8.addr", addrA, 16'h000C);
      checkOutput("c8.pc", pcA, 16'h0008);
      applyStimulus(0, 0, 0);
      for (int c = 9; c <= 18; c++) begin
         checkOutput($sformatf("c%0d.idleEn", c), enA, 0);
         checkOutput($sformatf("c%0d.holdValid", c), validA, 1);
         checkOutput($sformatf("c%0d.holdPc", c), pcA, 16'h0008);
         checkOutput($sformatf("c%0d.holdInstr", c), instrA, 32'hC0DE0008);
         applyStimulus(0, 0, 0);
      end
      applyStimulus(1, 0, 0);
      checkOutput("c20.pc", pcA, 16'h000C);
      checkOutput("c20.en", enA, 0);
      applyStimulus(1, 0, 0);
      checkOutput("c21.valid", validA, 0);
      checkOutput("c21.en", enA, 1);
      checkOutput("c21.addr", addrA, 16'h0010);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("c23.pc", pcA, 16'h0010);
      checkOutput("c23.addr", addrA, 16'h0014);
      applyStimulus(1, 0, 0);

      // Redirect while the response for 0x0014 is arriving.
      checkOutput("c24.ready", readyA, 1);
      applyStimulus(1, 1, 16'h0100);
      checkOutput("c25.valid", validA, 0);
      checkOutput("c25.addr", addrA, 16'h0100);
      checkOutput("c25.en", enA, 1);
      checkOutput("c25.mis", misA, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("c27.pc", pcA, 16'h0100);
      checkOutput("c27.instr", instrA, 32'hC0DE0100);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("c29.full.en", enA, 0);
      checkOutput("c29.full.pc", pcA, 16'h0100);

      // Misaligned redirect over a full buffer, pop requested at the same time.
      applyStimulus(1, 1, 16'h0102);
      checkOutput("c30.valid", validA, 0);
      checkOutput("c30.mis", misA, 1);
      checkOutput("c30.addr", addrA, 16'h0100);
      applyStimulus(1, 0, 0);
      checkOutput("c31.mis", misA, 0);
      applyStimulus(1, 0, 0);
      checkOutput("c32.pc", pcA, 16'h0100);
      checkOutput("c32.addr", addrA, 16'h0104);

      // Slow memory: three extra wait cycles per read.
      memLat = 4;
`ifdef IFETCH_STALL_CNT_EN
      stallBase = stallA;
`endif
      repeat (5) applyStimulus(1, 0, 0);
      checkOutput("c37.pc", pcA, 16'h0104);
      checkOutput("c37.instr", instrA, 32'hC0DE0104);
      checkOutput("c37.addr", addrA, 16'h0108);
`ifdef IFETCH_STALL_CNT_EN
      checkOutput("c37.stall", stallA, stallBase + 32'd4);
`endif
      repeat (5) applyStimulus(1, 0, 0);
      checkOutput("c42.pc", pcA, 16'h0108);
`ifdef IFETCH_STALL_CNT_EN
      checkOutput("c42.stall", stallA, stallBase + 32'd8);
`endif
      applyStimulus(1, 0, 0);
      checkOutput("c43.addr", addrA, 16'h010C);

      // Reset in the middle of an open read.
      rst = 1'b0;
      #1;
      checkOutput("midrst.en", enA, 0);
      checkOutput("midrst.valid", validA, 0);
      checkOutput("midrst.addr", addrA, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1, 0, 0);
      checkOutput("postrst.en", enA, 1);
      checkOutput("postrst.addr", addrA, 16'h0000);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
